rob_dual_commit: RTL

ROB_DUAL_COMMIT -- requirements
Module: rob_dual_commit

---
 rtl/rob_dual_commit.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/rob_dual_commit.sv
`default_nettype none
// ============================================================================
// Module   : rob_dual_commit
// Brief    : Reorder buffer with CDB writeback, operand bypass, up to two
//            in-order commits per cycle and branch/jalr mispredict flush.
// Revision : 1.0
// ============================================================================
module rob_dual_commit #(
    parameter int DEPTH    = 16,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int COMMIT_W = 2,
    localparam int IDX_W   = $clog2(DEPTH),
    localparam int TAG_W   = IDX_W + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_valid,
    input  logic [1:0]                   alloc_kind,
    input  logic [REG_W-1:0]             alloc_dest,
    input  logic [DATA_W-1:0]            alloc_pc,
    input  logic                         alloc_pred_taken,
    output logic                         alloc_ready,
    output logic [TAG_W-1:0]             alloc_tag,
    input  logic [TAG_W-1:0]             cdb0_tag,
    input  logic [DATA_W-1:0]            cdb0_value,
    input  logic                         cdb0_taken,
    input  logic [DATA_W-1:0]            cdb0_target,
    input  logic [TAG_W-1:0]             cdb1_tag,
    input  logic [DATA_W-1:0]            cdb1_value,
    input  logic [TAG_W-1:0]             q1_tag,
    input  logic [TAG_W-1:0]             q2_tag,
    output logic                         q1_ready,
    output logic [DATA_W-1:0]            q1_value,
    output logic                         q2_ready,
    output logic [DATA_W-1:0]            q2_value,
    output logic [COMMIT_W-1:0]          cm_valid,
    output logic [COMMIT_W*REG_W-1:0]    cm_reg,
    output logic [COMMIT_W*TAG_W-1:0]    cm_tag,
    output logic [COMMIT_W*DATA_W-1:0]   cm_value,
    output logic [TAG_W-1:0]             st_commit_tag,
    output logic                         bp_update,
    output logic [DATA_W-1:0]            bp_pc,
    output logic                         bp_taken,
    output logic                         flush,
    output logic [DATA_W-1:0]            redirect_pc,
    output logic [TAG_W-1:0]             count
);

    localparam logic [1:0]       KIND_REG    = 2'd0;
    localparam logic [1:0]       KIND_STORE  = 2'd1;
    localparam logic [1:0]       KIND_BRANCH = 2'd2;
    localparam logic [1:0]       KIND_JALR   = 2'd3;
    localparam logic [TAG_W-1:0] FULL        = TAG_W'(DEPTH);

    logic [1:0]        kind   [DEPTH];
    logic [REG_W-1:0]  dest   [DEPTH];
    logic [DATA_W-1:0] pc     [DEPTH];
    logic [DATA_W-1:0] value  [DEPTH];
    logic [DATA_W-1:0] target [DEPTH];
    logic              pred   [DEPTH];
    logic              taken  [DEPTH];
    logic [DEPTH-1:0]  ready_bits;

    logic [TAG_W-1:0]  head_ptr, tail_ptr, count_reg;

    logic [1:0]              cm_valid_reg;
    logic [2*REG_W-1:0]      cm_reg_reg;
    logic [2*TAG_W-1:0]      cm_tag_reg;
    logic [2*DATA_W-1:0]     cm_value_reg;
    logic [TAG_W-1:0]        st_tag_reg;
    logic                    bp_update_reg, bp_taken_reg, flush_reg;
    logic [DATA_W-1:0]       bp_pc_reg, redirect_reg;

    logic [IDX_W-1:0] h0, h1, t_idx, cdb0_idx, cdb1_idx, q1_idx, q2_idx;
    logic             alloc_fire, commit0, commit1, is_branch0, is_jalr0;
    logic             flush_now, cv0, cv1;
    logic [TAG_W-1:0] n_commit, tag0, tag1;

    assign h0       = head_ptr[IDX_W-1:0];
    assign h1       = h0 + IDX_W'(1);
    assign t_idx    = tail_ptr[IDX_W-1:0];
    assign cdb0_idx = IDX_W'(cdb0_tag - TAG_W'(1));
    assign cdb1_idx = IDX_W'(cdb1_tag - TAG_W'(1));
    assign q1_idx   = IDX_W'(q1_tag - TAG_W'(1));
    assign q2_idx   = IDX_W'(q2_tag - TAG_W'(1));
    assign tag0     = {1'b0, h0} + TAG_W'(1);
    assign tag1     = {1'b0, h1} + TAG_W'(1);

    assign alloc_ready = (count_reg < FULL) && !flush;
    assign alloc_tag   = {1'b0, t_idx} + TAG_W'(1);
    assign alloc_fire  = alloc_valid && alloc_ready;

    // Slot 1 only retires a plain reg-write that directly follows a reg-write.
    assign commit0    = (count_reg != '0) && ready_bits[h0];
    assign commit1    = (COMMIT_W == 2) && commit0 && (kind[h0] == KIND_REG)
                        && (kind[h1] == KIND_REG) && (count_reg > TAG_W'(1))
                        && ready_bits[h1];
    assign is_branch0 = (kind[h0] == KIND_BRANCH);
    assign is_jalr0   = (kind[h0] == KIND_JALR);
    assign flush_now  = commit0 && (is_jalr0 || (is_branch0 && (taken[h0] != pred[h0])));
    assign n_commit   = TAG_W'(commit0) + TAG_W'(commit1);
    assign cv0        = commit0 && ((kind[h0] == KIND_REG) || is_jalr0) && (dest[h0] != '0);
    assign cv1        = commit1 && (dest[h1] != '0);

    // Operand lookup with same-cycle CDB bypass; CDB0 wins over CDB1.
    always_comb begin
        q1_ready = 1'b0;
        q1_value = '0;
        q2_ready = 1'b0;
        q2_value = '0;
        if (q1_tag != '0) begin
            if (q1_tag == cdb0_tag) begin
                q1_ready = 1'b1;
                q1_value = cdb0_value;
            end else if (q1_tag == cdb1_tag) begin
                q1_ready = 1'b1;
                q1_value = cdb1_value;
            end else begin
                q1_ready = ready_bits[q1_idx];
                q1_value = value[q1_idx];
            end
        end
        if (q2_tag != '0) begin
            if (q2_tag == cdb0_tag) begin
                q2_ready = 1'b1;
                q2_value = cdb0_value;
            end else if (q2_tag == cdb1_tag) begin
                q2_ready = 1'b1;
                q2_value = cdb1_value;
            end else begin
                q2_ready = ready_bits[q2_idx];
                q2_value = value[q2_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr      <= '0;
            tail_ptr      <= '0;
            count_reg     <= '0;
            ready_bits    <= '0;
            cm_valid_reg  <= '0;
            cm_reg_reg    <= '0;
            cm_tag_reg    <= '0;
            cm_value_reg  <= '0;
            st_tag_reg    <= '0;
            bp_update_reg <= 1'b0;
            bp_pc_reg     <= '0;
            bp_taken_reg  <= 1'b0;
            flush_reg     <= 1'b0;
            redirect_reg  <= '0;
        end else begin
            cm_valid_reg  <= {cv1, cv0};
            cm_reg_reg    <= {dest[h1], dest[h0]};
            cm_tag_reg    <= {tag1, tag0};
            cm_value_reg  <= {value[h1], value[h0]};
            st_tag_reg    <= (commit0 && (kind[h0] == KIND_STORE)) ? tag0 : '0;
            bp_update_reg <= commit0 && (is_branch0 || is_jalr0);
            bp_pc_reg     <= pc[h0];
            bp_taken_reg  <= is_jalr0 || taken[h0];
            flush_reg     <= flush_now;
            redirect_reg  <= (is_jalr0 || taken[h0]) ? target[h0] : pc[h0] + DATA_W'(4);
            if (flush_now) begin
                head_ptr  <= '0;
                tail_ptr  <= '0;
                count_reg <= '0;
            end else begin
                head_ptr  <= head_ptr + n_commit;
                tail_ptr  <= tail_ptr + TAG_W'(alloc_fire);
                count_reg <= count_reg + TAG_W'(alloc_fire) - n_commit;
                if (cdb0_tag != '0) ready_bits[cdb0_idx] <= 1'b1;
                if (cdb1_tag != '0) ready_bits[cdb1_idx] <= 1'b1;
                if (alloc_fire)     ready_bits[t_idx]    <= 1'b0;
            end
        end
    end

    // Payload needs no reset: ready_bits gates every use of it.
    always_ff @(posedge clk) begin
        if (!flush_now) begin
            if (cdb0_tag != '0) begin
                value[cdb0_idx]  <= cdb0_value;
                taken[cdb0_idx]  <= cdb0_taken;
                target[cdb0_idx] <= cdb0_target;
            end
            if (cdb1_tag != '0) value[cdb1_idx] <= cdb1_value;
            if (alloc_fire) begin
                kind[t_idx] <= alloc_kind;
                dest[t_idx] <= alloc_dest;
                pc[t_idx]   <= alloc_pc;
                pred[t_idx] <= alloc_pred_taken;
            end
        end
    end

    assign cm_valid      = cm_valid_reg[COMMIT_W-1:0];
    assign cm_reg        = cm_reg_reg[COMMIT_W*REG_W-1:0];
    assign cm_tag        = cm_tag_reg[COMMIT_W*TAG_W-1:0];
    assign cm_value      = cm_value_reg[COMMIT_W*DATA_W-1:0];
    assign st_commit_tag = st_tag_reg;
    assign bp_update     = bp_update_reg;
    assign bp_pc         = bp_pc_reg;
    assign bp_taken      = bp_taken_reg;
    assign flush         = flush_reg;
    assign redirect_pc   = redirect_reg;
    assign count         = count_reg;

endmodule
`default_nettype wire
